// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: holds the core in reset until the synchronized PLL lock has
// stayed high long enough, retries failed lock attempts and flags a hard failure.
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int RW = $clog2(PLL_RST_CYCLES);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_RESET_PLL,
    ST_WAIT_LOCK,
    ST_STABILIZE,
    ST_RUN,
    ST_FAIL
  } state_e;

  state_e        state_q, state_d;
  logic          syncMeta_q;
  logic          lk_q;
  logic [RW-1:0] rstCnt_q, rstCnt_d;
  logic [TW-1:0] attTmr_q, attTmr_d;
  logic [SW-1:0] stableCnt_q, stableCnt_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          pllRst_q, pllRst_d;
  logic          sysRstN_q, sysRstN_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;
  logic          rstDone;
  logic          timeout;
  logic          qualified;

  assign rstDone   = (rstCnt_q == RW'(PLL_RST_CYCLES - 1));
  assign timeout   = (attTmr_q == TW'(LOCK_TIMEOUT_CYCLES - 1));
  assign qualified = (stableCnt_q == SW'(LOCK_STABLE_CYCLES - 1));

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      syncMeta_q <= 1'b0;
      lk_q       <= 1'b0;
    end else begin
      syncMeta_q <= pll_locked;
      lk_q       <= syncMeta_q;
    end
  end

  // Every way into RESET_PLL clears the pll_rst period counter so the pulse is always full length.
  always_comb begin
    state_d     = state_q;
    rstCnt_d    = rstCnt_q;
    attTmr_d    = attTmr_q;
    stableCnt_d = stableCnt_q;
    retry_d     = retry_q;
    loss_d      = loss_q;
    unique case (state_q)
      ST_RESET_PLL: begin
        if (restart) begin
          rstCnt_d = '0;
        end else if (rstDone) begin
          state_d  = ST_WAIT_LOCK;
          attTmr_d = '0;
        end else begin
          rstCnt_d = rstCnt_q + 1'b1;
        end
      end
      ST_WAIT_LOCK, ST_STABILIZE: begin
        if (restart) begin
          state_d  = ST_RESET_PLL;
          rstCnt_d = '0;
        end else if (timeout) begin
          retry_d  = retry_q + 1'b1;
          rstCnt_d = '0;
          state_d  = (retry_d == 4'(MAX_RETRIES)) ? ST_FAIL : ST_RESET_PLL;
        end else begin
          attTmr_d = attTmr_q + 1'b1;
          if (state_q == ST_WAIT_LOCK) begin
            if (lk_q) begin
              state_d     = ST_STABILIZE;
              stableCnt_d = '0;
            end
          end else if (!lk_q) begin
            state_d = ST_WAIT_LOCK;
          end else if (qualified) begin
            state_d = ST_RUN;
            retry_d = '0;
          end else begin
            stableCnt_d = stableCnt_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (restart) begin
          state_d  = ST_RESET_PLL;
          rstCnt_d = '0;
        end else if (!lk_q) begin
          state_d  = ST_RESET_PLL;
          rstCnt_d = '0;
          if (loss_q != 8'hFF) loss_d = loss_q + 1'b1;
        end
      end
      ST_FAIL: begin
        if (restart) begin
          state_d  = ST_RESET_PLL;
          rstCnt_d = '0;
          retry_d  = '0;
        end
      end
      default: begin
        state_d  = ST_RESET_PLL;
        rstCnt_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge as the state.
  always_comb begin
    pllRst_d  = (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
    sysRstN_d = (state_d == ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fail_d    = (state_d == ST_FAIL);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET_PLL;
      rstCnt_q    <= '0;
      attTmr_q    <= '0;
      stableCnt_q <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pllRst_q    <= 1'b1;
      sysRstN_q   <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rstCnt_q    <= rstCnt_d;
      attTmr_q    <= attTmr_d;
      stableCnt_q <= stableCnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pllRst_q    <= pllRst_d;
      sysRstN_q   <= sysRstN_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_rst   = pllRst_q;
  assign sys_rst_n = sysRstN_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed scoreboard bench for pll_lock_supervisor: expected values are queued as stimulus
// is applied and popped when the corresponding DUT output is observed.
module tb_pll_lock_supervisor;

  localparam int PRC = 4;
  localparam int LSC = 8;
  localparam int LTC = 32;
  localparam int MR  = 2;

  logic       refclk = 1'b0;
  logic       rst_n  = 1'b1;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int checks   = 0;
  int failures = 0;
  int lossModel;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];

  always #10 refclk = ~refclk;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES     (PRC),
    .LOCK_STABLE_CYCLES (LSC),
    .LOCK_TIMEOUT_CYCLES(LTC),
    .MAX_RETRIES        (MR)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic applyStimulus(input logic lockVal, input logic restartVal);
    pll_locked = lockVal;
    restart    = restartVal;
  endtask

  task automatic pushExpected(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pushState(input string tag, input int p, input int s, input int r,
                           input int f, input int rc, input int lc);
    pushExpected({tag, ".pll_rst"}, p);
    pushExpected({tag, ".sys_rst_n"}, s);
    pushExpected({tag, ".ready"}, r);
    pushExpected({tag, ".fail"}, f);
    pushExpected({tag, ".retry_cnt"}, rc);
    pushExpected({tag, ".loss_cnt"}, lc);
  endtask

  task automatic checkOutput(input int observed);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=%0d expected=none", observed);
    end else begin
      e = sb.pop_front();
      assert (observed === e.val) else begin
        failures++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", e.tag, observed, e.val);
      end
    end
  endtask

  task automatic checkState();
    checkOutput(int'(pll_rst));
    checkOutput(int'(sys_rst_n));
    checkOutput(int'(ready));
    checkOutput(int'(fail));
    checkOutput(int'(retry_cnt));
    checkOutput(int'(loss_cnt));
  endtask

  function automatic logic sigSel(input int sel);
    case (sel)
      0:       return pll_rst;
      1:       return sys_rst_n;
      2:       return ready;
      default: return fail;
    endcase
  endfunction

  // Counts edges until the selected output reaches val; returns maxN if it never does.
  task automatic waitFor(input int sel, input logic val, input int maxN, output int n);
    n = 0;
    while (sigSel(sel) !== val && n < maxN) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    applyStimulus(1'b0, 1'b0);
    lossModel = 0;

    // Asynchronous reset with no clock edge yet
    #1 rst_n = 1'b0;
    pushState("reset", 1, 0, 0, 0, 0, 0);
    #4;
    checkState();
    tick(2);
    rst_n = 1'b1;

    // Clean bring-up
    pushExpected("bringup.pll_rst_cycles", PRC);
    waitFor(0, 1'b0, 50, n);
    checkOutput(n);
    tick(3);
    applyStimulus(1'b1, 1'b0);
    pushExpected("bringup.lock_to_ready", 2 + 1 + LSC);
    waitFor(2, 1'b1, 100, n);
    checkOutput(n);
    pushState("bringup.run", 0, 1, 1, 0, 0, lossModel);
    checkState();

    // Lock loss in RUN
    applyStimulus(1'b0, 1'b0);
    lossModel++;
    pushExpected("loss.edges_to_sys_rst", 3);
    waitFor(1, 1'b0, 20, n);
    checkOutput(n);
    pushState("loss.reseq", 1, 0, 0, 0, 0, lossModel);
    checkState();
    applyStimulus(1'b1, 1'b0);
    pushExpected("loss.relock_ready", 1);
    waitFor(2, 1'b1, 100, n);
    checkOutput(int'(ready));

    // Restart in RUN, then a one-cycle glitch during STABILIZE
    applyStimulus(1'b1, 1'b1);
    pushState("restart.run", 1, 0, 0, 0, 0, lossModel);
    tick();
    applyStimulus(1'b1, 1'b0);
    checkState();
    pushExpected("restart.pll_rst_cycles", PRC);
    waitFor(0, 1'b0, 20, n);
    checkOutput(n);
    tick(3);
    applyStimulus(1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0);
    pushExpected("glitch.restore_to_ready", 2 + 1 + LSC);
    waitFor(2, 1'b1, 100, n);
    checkOutput(n);
    pushState("glitch.run", 0, 1, 1, 0, 0, lossModel);
    checkState();

    // Restart coinciding with synchronized lock loss: restart wins, no loss counted
    applyStimulus(1'b0, 1'b0);
    tick(2);
    applyStimulus(1'b0, 1'b1);
    pushState("simul.restart_loss", 1, 0, 0, 0, 0, lossModel);
    tick();
    applyStimulus(1'b0, 1'b0);
    checkState();

    // Never locks: first attempt times out, second one glitches but keeps its timer
    pushExpected("nolock.rst1", PRC);
    waitFor(0, 1'b0, 50, n);
    checkOutput(n);
    pushExpected("nolock.wait1", LTC);
    waitFor(0, 1'b1, 100, n);
    checkOutput(n);
    pushExpected("nolock.retry1", 1);
    checkOutput(int'(retry_cnt));
    pushExpected("nolock.rst2", PRC);
    waitFor(0, 1'b0, 50, n);
    checkOutput(n);
    pushExpected("nolock.wait2_timer_kept", LTC);
    n = 0;
    while (pll_rst !== 1'b1 && n < 100) begin
      applyStimulus((n >= 2 && n < 6), 1'b0);
      tick();
      n++;
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput(n);
    pushState("nolock.fail", 1, 0, 0, 1, MR, lossModel);
    checkState();
    tick(10);
    pushState("fail.hold", 1, 0, 0, 1, MR, lossModel);
    checkState();
    applyStimulus(1'b0, 1'b1);
    pushState("fail.restart", 1, 0, 0, 0, 0, lossModel);
    tick();
    applyStimulus(1'b0, 1'b0);
    checkState();
    pushExpected("fail.restart.pll_rst_cycles", PRC);
    waitFor(0, 1'b0, 20, n);
    checkOutput(n);

    // Repeated lock losses saturate loss_cnt
    applyStimulus(1'b1, 1'b0);
    pushExpected("relock.ready", 1);
    waitFor(2, 1'b1, 100, n);
    checkOutput(int'(ready));
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 1'b0);
      waitFor(1, 1'b0, 20, n);
      applyStimulus(1'b1, 1'b0);
      waitFor(2, 1'b1, 100, n);
      if (lossModel < 255) lossModel++;
      if (i == 0) begin
        pushExpected("loss.count_first", lossModel);
        checkOutput(int'(loss_cnt));
      end
    end
    pushState("loss.saturated", 0, 1, 1, 0, 0, lossModel);
    checkState();

    // rst_n asserted mid-STABILIZE acts without a clock edge
    applyStimulus(1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0);
    waitFor(0, 1'b0, 20, n);
    tick(3);
    #4;
    rst_n = 1'b0;
    pushState("async_reset", 1, 0, 0, 0, 0, 0);
    #1;
    checkState();
    tick();
    rst_n = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
